// File: rtl/acs_scheduler.sv
// Shared add-compare-select scheduler: one trellis state per clock, double-buffered path metrics.
// Optional ACS_NORM_EN: subtract 128 from all valid metrics at the bank swap when all have bit 7 set.
module acs_scheduler #(
  parameter  int NSTATES = 8,
  localparam int SW      = $clog2(NSTATES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [1:0]         sym_data,
  input  logic               frame_start,
  output logic [SW-1:0]      bm_state,
  output logic [1:0]         bm_sym,
  input  logic [1:0]         bm_0,
  input  logic [1:0]         bm_1,
  output logic               acs_p0_valid,
  output logic               acs_p1_valid,
  output logic [1:0]         acs_p0_bmc,
  output logic [1:0]         acs_p1_bmc,
  output logic [7:0]         acs_p0_pmc,
  output logic [7:0]         acs_p1_pmc,
  input  logic               acs_sel,
  input  logic               acs_valid,
  input  logic [7:0]         acs_cost,
  output logic               surv_valid,
  input  logic               surv_ready,
  output logic [NSTATES-1:0] surv_bits,
  output logic [SW-1:0]      best_state,
  output logic [7:0]         best_metric
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [SW-1:0]      cnt;
  logic               fs_q;
  logic [1:0]         sym_q;
  logic               best_found;
  logic [NSTATES-1:0] old_v;
  logic [NSTATES-1:0] new_v;
  logic [7:0]         old_m [NSTATES];
  logic [7:0]         new_m [NSTATES];

  logic [SW-1:0] p0_idx, p1_idx;
  logic          p0_v, p1_v;
  logic [7:0]    p0_m, p1_m;
  logic          in_run;

  assign p0_idx   = {cnt[SW-2:0], 1'b0};
  assign p1_idx   = {cnt[SW-2:0], 1'b1};
  assign in_run   = (state == RUN);
  assign bm_state = cnt;
  assign bm_sym   = sym_q;

  // A frame start reads the old bank as the init image: only state 0 valid, all metrics zero.
  always_comb begin
    p0_v = fs_q ? (p0_idx == '0) : old_v[p0_idx];
    p1_v = fs_q ? (p1_idx == '0) : old_v[p1_idx];
    p0_m = fs_q ? 8'd0 : old_m[p0_idx];
    p1_m = fs_q ? 8'd0 : old_m[p1_idx];
  end

  assign acs_p0_valid = in_run & p0_v;
  assign acs_p1_valid = in_run & p1_v;
  assign acs_p0_pmc   = in_run ? p0_m : 8'd0;
  assign acs_p1_pmc   = in_run ? p1_m : 8'd0;
  assign acs_p0_bmc   = in_run ? bm_0 : 2'd0;
  assign acs_p1_bmc   = in_run ? bm_1 : 2'd0;

`ifdef ACS_NORM_EN
  logic norm_all;
  always_comb begin
    norm_all = 1'b1;
    for (int i = 0; i < NSTATES; i++)
      if (new_v[i] && !new_m[i][7]) norm_all = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      fs_q        <= 1'b0;
      sym_q       <= 2'd0;
      sym_ready   <= 1'b1;
      surv_valid  <= 1'b0;
      surv_bits   <= '0;
      best_state  <= '0;
      best_metric <= 8'd0;
      best_found  <= 1'b0;
      for (int i = 0; i < NSTATES; i++) begin
        old_v[i] <= (i == 0);
        new_v[i] <= (i == 0);
        old_m[i] <= 8'd0;
        new_m[i] <= 8'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (sym_valid) begin
            sym_q       <= sym_data;
            fs_q        <= frame_start;
            cnt         <= '0;
            best_state  <= '0;
            best_metric <= 8'd0;
            best_found  <= 1'b0;
            sym_ready   <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          new_v[cnt]     <= acs_valid;
          new_m[cnt]     <= acs_valid ? acs_cost : 8'd0;
          surv_bits[cnt] <= acs_valid & acs_sel;
          // Strict less-than keeps the lowest index among equal metrics.
          if (acs_valid && (!best_found || acs_cost < best_metric)) begin
            best_state  <= cnt;
            best_metric <= acs_cost;
            best_found  <= 1'b1;
          end
          if (cnt == SW'(NSTATES - 1)) begin
            surv_valid <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (surv_ready) begin
            surv_valid <= 1'b0;
            sym_ready  <= 1'b1;
            state      <= IDLE;
            for (int i = 0; i < NSTATES; i++) begin
              old_v[i] <= new_v[i];
`ifdef ACS_NORM_EN
              old_m[i] <= (norm_all && new_v[i]) ? {1'b0, new_m[i][6:0]} : new_m[i];
`else
              old_m[i] <= new_m[i];
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler (NSTATES=4): trellis-level model per symbol, per-cycle compare, directed scenarios.
module tb_acs_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sym_valid = 1'b0, sym_ready, frame_start = 1'b0, surv_valid, surv_ready = 1'b0;
  logic [1:0]    sym_data = 2'd0, bm_sym, bm_0, bm_1, acs_p0_bmc, acs_p1_bmc;
  logic [SW-1:0] bm_state, best_state;
  logic          acs_p0_valid, acs_p1_valid, acs_sel, acs_valid;
  logic [7:0]    acs_p0_pmc, acs_p1_pmc, acs_cost, best_metric;
  logic [N-1:0]  surv_bits;

  acs_scheduler #(.NSTATES(N)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_data(sym_data), .frame_start(frame_start), .bm_state(bm_state), .bm_sym(bm_sym),
    .bm_0(bm_0), .bm_1(bm_1), .acs_p0_valid(acs_p0_valid), .acs_p1_valid(acs_p1_valid),
    .acs_p0_bmc(acs_p0_bmc), .acs_p1_bmc(acs_p1_bmc), .acs_p0_pmc(acs_p0_pmc),
    .acs_p1_pmc(acs_p1_pmc), .acs_sel(acs_sel), .acs_valid(acs_valid), .acs_cost(acs_cost),
    .surv_valid(surv_valid), .surv_ready(surv_ready), .surv_bits(surv_bits),
    .best_state(best_state), .best_metric(best_metric)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Bench-side branch-metric unit and ACS.
  logic [1:0] tb_b0 = 2'd0, tb_b1 = 2'd0;
  logic       tb_force = 1'b0;
  logic [7:0] tc0, tc1;
  assign bm_0 = tb_b0;
  assign bm_1 = tb_b1;

  always_comb begin
    tc0       = acs_p0_pmc + 8'(acs_p0_bmc);
    tc1       = acs_p1_pmc + 8'(acs_p1_bmc);
    acs_valid = acs_p0_valid | acs_p1_valid;
    if (acs_p0_valid && acs_p1_valid) acs_sel = tb_force ? bm_state[0] : (tc1 < tc0);
    else                              acs_sel = acs_p1_valid;
    acs_cost = !acs_valid ? 8'd0 : (acs_sel ? tc1 : tc0);
  end

  // Model: whole-symbol trellis update computed at acceptance; phase gives the expected timeline.
  int   m_phase = 0;
  bit   m_init = 0, m_fs = 0, m_force = 0;
  int   m_sym = 0, m_b0 = 0, m_b1 = 0;
  bit   bk_v[N], mv_v[N], nx_v[N];
  int   bk_m[N], mv_m[N], nx_m[N];
  int   m_surv = 0, m_bs = 0, m_bm = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1;
      m_phase = 0;
      for (int i = 0; i < N; i++) begin bk_v[i] = (i == 0); bk_m[i] = 0; end
    end else if (m_init) begin
      if (m_phase == 0) begin
        if (sym_valid) begin
          bit found;
          m_fs = frame_start; m_sym = sym_data; m_b0 = tb_b0; m_b1 = tb_b1; m_force = tb_force;
          for (int i = 0; i < N; i++) begin
            mv_v[i] = m_fs ? (i == 0) : bk_v[i];
            mv_m[i] = m_fs ? 0 : bk_m[i];
          end
          m_surv = 0; m_bs = 0; m_bm = 0; found = 0;
          for (int s = 0; s < N; s++) begin
            int p0, p1, c0, c1, cost;
            bit v, sel;
            p0 = (2 * s) % N; p1 = p0 + 1;
            c0 = (mv_m[p0] + m_b0) % 256;
            c1 = (mv_m[p1] + m_b1) % 256;
            v  = mv_v[p0] || mv_v[p1];
            if (mv_v[p0] && mv_v[p1]) sel = m_force ? (s % 2 == 1) : (c1 < c0);
            else                      sel = mv_v[p1];
            cost = sel ? c1 : c0;
            nx_v[s] = v;
            nx_m[s] = v ? cost : 0;
            if (v && sel) m_surv += (1 << s);
            if (v && (!found || cost < m_bm)) begin m_bs = s; m_bm = cost; found = 1; end
          end
          m_phase = 1;
        end
      end else if (m_phase <= N) begin
        m_phase++;
      end else if (surv_ready) begin
        bit all_hi;
        all_hi = 1;
        for (int i = 0; i < N; i++) if (nx_v[i] && nx_m[i] < 128) all_hi = 0;
        for (int i = 0; i < N; i++) begin
          bk_v[i] = nx_v[i];
`ifdef ACS_NORM_EN
          bk_m[i] = (all_hi && nx_v[i]) ? nx_m[i] - 128 : nx_m[i];
`else
          bk_m[i] = nx_m[i];
`endif
        end
        m_phase = 0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      if (m_phase == 0) begin
        check("idle_sym_ready", sym_ready, 1);
        check("idle_surv_valid", surv_valid, 0);
        check("idle_p0_valid", acs_p0_valid, 0);
        check("idle_p1_valid", acs_p1_valid, 0);
      end else if (m_phase <= N) begin
        int c, p0, p1;
        c = m_phase - 1; p0 = (2 * c) % N; p1 = p0 + 1;
        check("run_sym_ready", sym_ready, 0);
        check("run_surv_valid", surv_valid, 0);
        check("run_bm_state", bm_state, c);
        check("run_bm_sym", bm_sym, m_sym);
        check("run_p0_valid", acs_p0_valid, mv_v[p0]);
        check("run_p1_valid", acs_p1_valid, mv_v[p1]);
        check("run_p0_pmc", acs_p0_pmc, mv_m[p0]);
        check("run_p1_pmc", acs_p1_pmc, mv_m[p1]);
        check("run_p0_bmc", acs_p0_bmc, m_b0);
        check("run_p1_bmc", acs_p1_bmc, m_b1);
      end else begin
        check("done_sym_ready", sym_ready, 0);
        check("done_surv_valid", surv_valid, 1);
        check("done_surv_bits", surv_bits, m_surv);
        check("done_best_state", best_state, m_bs);
        check("done_best_metric", best_metric, m_bm);
        check("done_p0_valid", acs_p0_valid, 0);
        check("done_p1_valid", acs_p1_valid, 0);
      end
    end
  end

  int last_surv, last_bs, last_bm;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit fs, input logic [1:0] sd, input logic [1:0] b0,
                      input logic [1:0] b1, input bit force_odd, input int hold,
                      input bit keep_valid);
    bit ok;
    int lat;
    tb_b0 = b0; tb_b1 = b1; tb_force = force_odd;
    sym_data = sd; frame_start = fs; sym_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (sym_ready) ok = 1;
      tick();
    end
    check("accept_timeout", ok, 1);
    if (keep_valid) sym_data = ~sd;
    else begin sym_valid = 1'b0; frame_start = 1'b0; end
    lat = 0;
    while (!surv_valid && lat < 20) begin tick(); lat++; end
    check("surv_latency", lat, N);
    sym_valid = 1'b0; frame_start = 1'b0;
    repeat (hold) tick();
    last_surv = surv_bits; last_bs = best_state; last_bm = best_metric;
    surv_ready = 1'b1;
    tick();
    surv_ready = 1'b0;
    check("post_handshake_ready", sym_ready, 1);
  endtask

  initial begin
    int guard;
    repeat (2) tick();
    check("rst_sym_ready", sym_ready, 1);
    check("rst_surv_valid", surv_valid, 0);
    check("rst_bm_state", bm_state, 0);
    check("rst_p0_pmc", acs_p0_pmc, 0);
    check("rst_p1_bmc", acs_p1_bmc, 0);
    check("rst_surv_bits", surv_bits, 0);
    check("rst_best_metric", best_metric, 0);
    rst = 1'b0;
    tick();

    // First symbol after reset, held 5 cycles in DONE.
    send(1, 2'b00, 2'd1, 2'd1, 0, 5, 0);
    check("s1_surv_bits", last_surv, 0);
    check("s1_best_state", last_bs, 0);
    check("s1_best_metric", last_bm, 1);

    // Continuation; sym_valid kept high with changing data during RUN.
    send(0, 2'b10, 2'd1, 2'd1, 0, 1, 1);
    check("s2_surv_bits", last_surv, 0);
    check("s2_best_metric", last_bm, 2);

    // Odd states select predecessor 1; all metrics tie.
    send(0, 2'b01, 2'd1, 2'd1, 1, 1, 0);
    check("odd_surv_bits", last_surv, 4'b1010);
    check("odd_best_state", last_bs, 0);
    check("odd_best_metric", last_bm, 3);

    // Mid-stream frame start.
    send(1, 2'b11, 2'd1, 2'd1, 0, 1, 0);
    check("mid_fs_surv_bits", last_surv, 0);
    check("mid_fs_best_state", last_bs, 0);
    check("mid_fs_best_metric", last_bm, 1);

    // Long stream with bm=3.
    for (int k = 1; k <= 43; k++) send(k == 1, 2'b00, 2'd3, 2'd3, 0, 0, 0);
    check("stream43_best_metric", last_bm, 129);
`ifdef ACS_NORM_EN
    send(0, 2'b00, 2'd3, 2'd3, 0, 0, 0);
    check("norm_best_metric", last_bm, 4);
`else
    for (int k = 44; k <= 86; k++) send(0, 2'b00, 2'd3, 2'd3, 0, 0, 0);
    check("wrap86_best_metric", last_bm, 2);
`endif

    // Reset at RUN counter 2.
    tb_b0 = 2'd3; tb_b1 = 2'd3; tb_force = 1'b0;
    sym_data = 2'b01; frame_start = 1'b0; sym_valid = 1'b1;
    guard = 0;
    while (!sym_ready && guard < 20) begin tick(); guard++; end
    tick();
    sym_valid = 1'b0;
    guard = 0;
    while (m_phase != 3 && guard < 20) begin tick(); guard++; end
    check("reach_run_c2", bm_state, 2);
    rst = 1'b1;
    tick();
    check("midrun_rst_sym_ready", sym_ready, 1);
    check("midrun_rst_surv_valid", surv_valid, 0);
    rst = 1'b0;
    send(0, 2'b00, 2'd1, 2'd1, 0, 1, 0);
    check("after_rst_surv_bits", last_surv, 0);
    check("after_rst_best_state", last_bs, 0);
    check("after_rst_best_metric", last_bm, 1);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
